// File: rtl/mdu_pkg.sv
// Shared encodings, FSM states and negation helpers for the HI/LO multiply/divide sequencer.
package mdu_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam int ITER_CNT = 32;
  localparam int CNT_W    = 5;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] x);
    return ~x + 64'd1;
  endfunction

  // 0x80000000 maps to itself, which read as unsigned is the correct 2^31.
  function automatic logic [31:0] abs32(input logic [31:0] x, input logic is_signed);
    return (is_signed && x[31]) ? neg32(x) : x;
  endfunction

endpackage

// File: rtl/bit_32_mixed_adder_8.sv
// 32-bit adder built from four 8-bit slices, with bitwise AND/OR/XOR side outputs.
module bit_32_mixed_adder_8 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        c_i,
  output logic [31:0] sum_o,
  output logic        c_o,
  output logic [31:0] and_o,
  output logic [31:0] or_o,
  output logic [31:0] xor_o
);

  logic c8_s;
  logic c16_s;
  logic c24_s;

  assign {c8_s,  sum_o[7:0]}   = {1'b0, a_i[7:0]}   + {1'b0, b_i[7:0]}   + {8'd0, c_i};
  assign {c16_s, sum_o[15:8]}  = {1'b0, a_i[15:8]}  + {1'b0, b_i[15:8]}  + {8'd0, c8_s};
  assign {c24_s, sum_o[23:16]} = {1'b0, a_i[23:16]} + {1'b0, b_i[23:16]} + {8'd0, c16_s};
  assign {c_o,   sum_o[31:24]} = {1'b0, a_i[31:24]} + {1'b0, b_i[31:24]} + {8'd0, c24_s};

  assign and_o = a_i & b_i;
  assign or_o  = a_i | b_i;
  assign xor_o = a_i ^ b_i;

endmodule

// File: rtl/mdu_seq_ctrl.sv
// MULT/MULTU/DIV/DIVU sequencer: sign fix-up around 32 shift-add or restoring-divide
// iterations that all share one 32-bit adder.
module mdu_seq_ctrl
  import mdu_pkg::*;
#(
  parameter int ITER = ITER_CNT
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        start_in,
  input  logic [1:0]  op_in,
  input  logic [31:0] A_in,
  input  logic [31:0] B_in,
  output logic        busy_out,
  output logic        done_out,
  output logic        div_zero_out,
  output logic [31:0] HI_out,
  output logic [31:0] LO_out
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [31:0]       a_q, a_d, b_q, b_d;
  logic [31:0]       m_q, m_d;             // |A| for multiply, |B| for divide
  logic [31:0]       acc_hi_q, acc_hi_d;   // multiply HI / divide remainder
  logic [31:0]       acc_lo_q, acc_lo_d;   // multiply LO / divide quotient
  logic              neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d, done_q, done_d, dz_q, dz_d;
  logic [31:0]       hi_out_q, hi_out_d, lo_out_q, lo_out_d;

  logic [31:0] add_a_s, add_b_s, add_sum_s;
  logic        add_c_s, add_cout_s;
  logic [31:0] adder_and_unused_s, adder_or_unused_s, adder_xor_unused_s;
  logic        mul_c_s;
  logic [31:0] mul_hi_s;

  logic is_div_s, is_signed_s, div_by_zero_s;
  assign is_div_s      = op_q[1];
  assign is_signed_s   = ~op_q[0];
  assign div_by_zero_s = is_div_s && (b_q == 32'd0);

  bit_32_mixed_adder_8 u_adder (
    .a_i   (add_a_s),
    .b_i   (add_b_s),
    .c_i   (add_c_s),
    .sum_o (add_sum_s),
    .c_o   (add_cout_s),
    .and_o (adder_and_unused_s),
    .or_o  (adder_or_unused_s),
    .xor_o (adder_xor_unused_s)
  );

  // Shared adder operands: HI + |A| for multiply, shifted R - |B| for divide.
  always_comb begin
    add_a_s  = acc_hi_q;
    add_b_s  = m_q;
    add_c_s  = 1'b0;
    mul_c_s  = 1'b0;
    mul_hi_s = acc_hi_q;
    if (is_div_s) begin
      add_a_s = {acc_hi_q[30:0], acc_lo_q[31]};
      add_b_s = ~m_q;
      add_c_s = 1'b1;
    end else begin
      add_a_s = acc_hi_q;
      add_b_s = m_q;
      add_c_s = 1'b0;
    end
    if (acc_lo_q[0]) begin
      mul_c_s  = add_cout_s;
      mul_hi_s = add_sum_s;
    end else begin
      mul_c_s  = 1'b0;
      mul_hi_s = acc_hi_q;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_in) state_d = S_PREP; else state_d = S_IDLE;
      S_PREP:  if (div_by_zero_s) state_d = S_DONE; else state_d = S_ITER;
      S_ITER:  if (cnt_q == LAST_CNT) state_d = S_FIX; else state_d = S_ITER;
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result fix-up.
  always_comb begin
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    m_d       = m_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    cnt_d     = cnt_q;
    hi_out_d  = hi_out_q;
    lo_out_d  = lo_out_q;
    busy_d    = state_d inside {S_PREP, S_ITER, S_FIX};
    done_d    = (state_d == S_DONE);
    dz_d      = (state_q == S_PREP) && div_by_zero_s;
    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          op_d = op_in;
          a_d  = A_in;
          b_d  = B_in;
        end else begin
          op_d = op_q;
        end
      end
      S_PREP: begin
        neg_res_d = is_signed_s & (a_q[31] ^ b_q[31]);
        neg_rem_d = is_signed_s & a_q[31];
        cnt_d     = '0;
        acc_hi_d  = 32'd0;
        if (is_div_s) begin
          m_d      = abs32(b_q, is_signed_s);
          acc_lo_d = abs32(a_q, is_signed_s);
        end else begin
          m_d      = abs32(a_q, is_signed_s);
          acc_lo_d = abs32(b_q, is_signed_s);
        end
        if (div_by_zero_s) begin
          hi_out_d = a_q;
          lo_out_d = 32'hFFFF_FFFF;
        end else begin
          hi_out_d = hi_out_q;
        end
      end
      S_ITER: begin
        cnt_d = cnt_q + CNT_ONE;
        if (is_div_s) begin
          // A carry, or a bit shifted out of R, means R >= |B|.
          if (acc_hi_q[31] | add_cout_s) begin
            acc_hi_d = add_sum_s;
            acc_lo_d = {acc_lo_q[30:0], 1'b1};
          end else begin
            acc_hi_d = add_a_s;
            acc_lo_d = {acc_lo_q[30:0], 1'b0};
          end
        end else begin
          acc_hi_d = {mul_c_s, mul_hi_s[31:1]};
          acc_lo_d = {mul_hi_s[0], acc_lo_q[31:1]};
        end
      end
      S_FIX: begin
        case (op_q)
          OP_MULT, OP_MULTU: begin
            if (neg_res_q) begin
              {hi_out_d, lo_out_d} = neg64({acc_hi_q, acc_lo_q});
            end else begin
              {hi_out_d, lo_out_d} = {acc_hi_q, acc_lo_q};
            end
          end
          OP_DIV, OP_DIVU: begin
            lo_out_d = neg_res_q ? neg32(acc_lo_q) : acc_lo_q;
            hi_out_d = neg_rem_q ? neg32(acc_hi_q) : acc_hi_q;
          end
          default: begin
            hi_out_d = hi_out_q;
            lo_out_d = lo_out_q;
          end
        endcase
      end
      S_DONE: begin
        cnt_d = '0;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Datapath and output registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      op_q      <= 2'b00;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      m_q       <= 32'd0;
      acc_hi_q  <= 32'd0;
      acc_lo_q  <= 32'd0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      hi_out_q  <= 32'd0;
      lo_out_q  <= 32'd0;
    end else begin
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      m_q       <= m_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
      hi_out_q  <= hi_out_d;
      lo_out_q  <= lo_out_d;
    end
  end

  assign busy_out     = busy_q;
  assign done_out     = done_q;
  assign div_zero_out = dz_q;
  assign HI_out       = hi_out_q;
  assign LO_out       = lo_out_q;

endmodule
